// File: rtl/gate_truth_table_decoder.sv
// -----------------------------------------------------------------------------
// gate_truth_table_decoder
//
// Purpose:
//   Exercises an external 2-input gate by driving its inputs through the four
//   combinations 00, 01, 10, 11. Each combination is held for SETTLE_CYCLES
//   clock cycles, then the gate output is sampled for one cycle. The four
//   samples form a truth table. That table is decoded to a gate identity
//   (AND/OR/NOT(a)/NAND/NOR/XOR/XNOR), or to "unknown" if it matches none.
//   The block also flags an output that moved between the last settle cycle
//   and the sample cycle.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (legal 1..15)
//
// Ports:
//   clk          in   1  clock, all state updates on the rising edge
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  begin a sweep; only honoured while idle
//   abort        in   1  cancel a sweep in progress and return to idle
//   a_o          out  1  stimulus to gate input a
//   b_o          out  1  stimulus to gate input b
//   y_i          in   1  observed gate output
//   busy         out  1  high from the cycle after start until DONE
//   done         out  1  one-cycle pulse when results become valid
//   truth_table  out  4  truth_table[{a,b}] = sampled y_i
//   gate_id      out  3  0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR,
//                        6 XNOR, 7 unknown
//   valid_gate   out  1  gate_id != 7
//   unstable     out  1  y_i moved between last settle cycle and sample cycle
// -----------------------------------------------------------------------------
module gate_truth_table_decoder #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a_o,
    output logic       b_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] gate_id,
    output logic       valid_gate,
    output logic       unstable
);

    // Gate identity codes.
    localparam logic [2:0] ID_AND     = 3'd0;
    localparam logic [2:0] ID_OR      = 3'd1;
    localparam logic [2:0] ID_NOTA    = 3'd2;
    localparam logic [2:0] ID_NAND    = 3'd3;
    localparam logic [2:0] ID_NOR     = 3'd4;
    localparam logic [2:0] ID_XOR     = 3'd5;
    localparam logic [2:0] ID_XNOR    = 3'd6;
    localparam logic [2:0] ID_UNKNOWN = 3'd7;

    // The settle counter runs 0 .. SETTLE_CYCLES-1 while a vector is driven.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q;
    logic [1:0] idx_q;
    logic [3:0] settle_q;
    logic       a_q;
    logic       b_q;
    logic       y_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] tt_q;
    logic [2:0] gate_id_q;
    logic       valid_q;
    logic       unstable_q;

    logic [3:0] tt_d;
    logic [2:0] gate_id_d;
    logic [1:0] idx_next;

    // Maps a complete truth table (bit3..0 = inputs 11,10,01,00) to a gate.
    function automatic logic [2:0] decode_gate(input logic [3:0] tt);
        logic [2:0] id;
        case (tt)
            4'b1000: id = ID_AND;
            4'b1110: id = ID_OR;
            4'b0011: id = ID_NOTA;
            4'b0111: id = ID_NAND;
            4'b0001: id = ID_NOR;
            4'b0110: id = ID_XOR;
            4'b1001: id = ID_XNOR;
            default: id = ID_UNKNOWN;
        endcase
        return id;
    endfunction

    // Truth table as it will look once the current sample is written.
    // Decoding this (rather than tt_q) lets gate_id update in the same cycle
    // that done rises, because the last entry is captured on that same edge.
    always_comb begin
        tt_d         = tt_q;
        tt_d[idx_q]  = y_i;
        gate_id_d    = decode_gate(tt_d);
        idx_next     = idx_q + 2'd1;
    end

    // Sweep sequencer. All outputs are registered here. An abort during
    // DRIVE or SAMPLE throws away the partial table and any previous result.
    // Once DONE is reached, the done pulse always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            settle_q   <= 4'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            y_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_q       <= 4'd0;
            gate_id_q  <= ID_UNKNOWN;
            valid_q    <= 1'b0;
            unstable_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (abort && (state_q == DRIVE || state_q == SAMPLE)) begin
                state_q    <= IDLE;
                idx_q      <= 2'd0;
                settle_q   <= 4'd0;
                a_q        <= 1'b0;
                b_q        <= 1'b0;
                busy_q     <= 1'b0;
                tt_q       <= 4'd0;
                gate_id_q  <= ID_UNKNOWN;
                valid_q    <= 1'b0;
                unstable_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // abort takes priority over start when both are
                        // asserted in the same cycle.
                        if (start && !abort) begin
                            state_q    <= DRIVE;
                            idx_q      <= 2'd0;
                            settle_q   <= 4'd0;
                            a_q        <= 1'b0;
                            b_q        <= 1'b0;
                            busy_q     <= 1'b1;
                            tt_q       <= 4'd0;
                            unstable_q <= 1'b0;
                        end
                    end

                    DRIVE: begin
                        // y_q holds the output seen on the last settle cycle.
                        // SAMPLE compares against it to detect instability.
                        y_q <= y_i;
                        if (settle_q == SETTLE_LAST) begin
                            settle_q <= 4'd0;
                            state_q  <= SAMPLE;
                        end else begin
                            settle_q <= settle_q + 4'd1;
                        end
                    end

                    SAMPLE: begin
                        tt_q <= tt_d;
                        if (y_i != y_q) begin
                            unstable_q <= 1'b1;
                        end
                        if (idx_q == 2'd3) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            gate_id_q <= gate_id_d;
                            valid_q   <= (gate_id_d != ID_UNKNOWN);
                            a_q       <= 1'b0;
                            b_q       <= 1'b0;
                        end else begin
                            idx_q   <= idx_next;
                            a_q     <= idx_next[1];
                            b_q     <= idx_next[0];
                            state_q <= DRIVE;
                        end
                    end

                    DONE: begin
                        state_q <= IDLE;
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign gate_id     = gate_id_q;
    assign valid_gate  = valid_q;
    assign unstable    = unstable_q;

endmodule

// File: tb/tb_gate_truth_table_decoder.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_table_decoder
//
// Purpose:
//   Bench for gate_truth_table_decoder. A behavioural "gate under test"
//   drives y_i from a_o/b_o according to a selectable mode. Each sweep pushes
//   its expected results into a scoreboard queue, and a monitor pops and
//   compares them whenever done pulses. Corner cases (abort, reset mid-sweep,
//   start while busy, output glitch) are driven as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_gate_truth_table_decoder;

    localparam int SETTLE  = 2;
    localparam int LATENCY = 4 * (SETTLE + 1);

    typedef struct {
        int         mode;
        logic [3:0] tt;
        logic [2:0] id;
        logic       valid;
        logic       unst;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       a_o;
    logic       b_o;
    logic       y_i;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_id;
    logic       valid_gate;
    logic       unstable;

    int   mode;
    logic glitch;
    int   nCompared;
    int   nMismatched;
    vec_t sbQ[$];
    vec_t mon;
    vec_t vecs[10];
    vec_t glitchVec;

    gate_truth_table_decoder #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .a_o        (a_o),
        .b_o        (b_o),
        .y_i        (y_i),
        .busy       (busy),
        .done       (done),
        .truth_table(truth_table),
        .gate_id    (gate_id),
        .valid_gate (valid_gate),
        .unstable   (unstable)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the gate being identified.
    function automatic logic gateModel(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return a | b;
            2:       return ~a;
            3:       return ~(a & b);
            4:       return ~(a | b);
            5:       return a ^ b;
            6:       return ~(a ^ b);
            7:       return 1'b1;
            8:       return 1'b0;
            default: return b;
        endcase
    endfunction

    // glitch flips the output only while vector 10 is being driven.
    assign y_i = gateModel(mode, a_o, b_o) ^ (glitch & a_o & ~b_o);

    task automatic checkOutput(input string what, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", what, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected done", int'(done), 0);
            end else begin
                mon = sbQ.pop_front();
                checkOutput("truth_table", int'(truth_table), int'(mon.tt));
                checkOutput("gate_id", int'(gate_id), int'(mon.id));
                checkOutput("valid_gate", int'(valid_gate), int'(mon.valid));
                checkOutput("unstable", int'(unstable), int'(mon.unst));
            end
        end
    end

    // One full sweep. glitchAt / restartAt name the negedge (counted from the
    // start edge) at which the glitch or a second start is raised for one cycle.
    // Zero disables them. abortInDone raises abort while done is high.
    task automatic applyStimulus(input vec_t v, input int glitchAt,
                                 input int restartAt, input bit abortInDone);
        int cyc;
        mode = v.mode;
        @(negedge clk);
        start = 1'b1;
        sbQ.push_back(v);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        checkOutput("busy after start", int'(busy), 1);
        while (done !== 1'b1 && cyc < 4 * LATENCY) begin
            @(negedge clk);
            cyc++;
            if (cyc == glitchAt)      glitch = 1'b1;
            if (cyc == glitchAt + 1)  glitch = 1'b0;
            if (cyc == restartAt)     start = 1'b1;
            if (cyc == restartAt + 1) start = 1'b0;
        end
        glitch = 1'b0;
        start  = 1'b0;
        checkOutput("sweep latency", cyc, LATENCY);
        if (abortInDone) abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("done single cycle", int'(done), 0);
        checkOutput("busy after done", int'(busy), 0);
        if (abortInDone) begin
            checkOutput("gate_id held after abort in DONE", int'(gate_id), int'(v.id));
            checkOutput("valid held after abort in DONE", int'(valid_gate), int'(v.valid));
        end
    endtask

    initial begin
        int nDone;
        nCompared   = 0;
        nMismatched = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mode   = 0;
        glitch = 1'b0;

        //               mode  tt       id    valid unst
        vecs[0] = '{0, 4'b1000, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{1, 4'b1110, 3'd1, 1'b1, 1'b0};
        vecs[2] = '{2, 4'b0011, 3'd2, 1'b1, 1'b0};
        vecs[3] = '{3, 4'b0111, 3'd3, 1'b1, 1'b0};
        vecs[4] = '{5, 4'b0110, 3'd5, 1'b1, 1'b0};
        vecs[5] = '{4, 4'b0001, 3'd4, 1'b1, 1'b0};
        vecs[6] = '{6, 4'b1001, 3'd6, 1'b1, 1'b0};
        vecs[7] = '{7, 4'b1111, 3'd7, 1'b0, 1'b0};
        vecs[8] = '{8, 4'b0000, 3'd7, 1'b0, 1'b0};
        vecs[9] = '{9, 4'b1010, 3'd7, 1'b0, 1'b0};
        // AND whose vector-10 sample reads 1 after a late flip.
        glitchVec = '{0, 4'b1100, 3'd7, 1'b0, 1'b1};

        #12;
        checkOutput("reset a_o", int'(a_o), 0);
        checkOutput("reset b_o", int'(b_o), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset truth_table", int'(truth_table), 0);
        checkOutput("reset gate_id", int'(gate_id), 7);
        checkOutput("reset valid_gate", int'(valid_gate), 0);
        checkOutput("reset unstable", int'(unstable), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All gate types plus unknown patterns, XOR then NOR back-to-back.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], 0, 0, 1'b0);
        end

        // Output flips after the last settle cycle of vector 10.
        applyStimulus(glitchVec, 8, 0, 1'b0);
        // A clean sweep must clear the sticky unstable flag.
        applyStimulus(vecs[0], 0, 0, 1'b0);
        // A second start mid-sweep must not restart (latency stays the same).
        applyStimulus(vecs[1], 0, 4, 1'b0);
        // An abort while done is high does not disturb the results.
        applyStimulus(vecs[4], 0, 0, 1'b1);

        // Abort at cycle 5 of an XNOR sweep, with an ignored start before it.
        mode = 6;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy before abort", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort gate_id", int'(gate_id), 7);
        checkOutput("abort valid_gate", int'(valid_gate), 0);
        checkOutput("abort truth_table", int'(truth_table), 0);
        checkOutput("abort a_o", int'(a_o), 0);
        checkOutput("abort b_o", int'(b_o), 0);
        nDone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) nDone++;
            if (busy === 1'b1) nDone++;
        end
        checkOutput("idle after abort", nDone, 0);

        // start and abort together while idle: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start+abort busy", int'(busy), 0);
        nDone = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy === 1'b1) nDone++;
        end
        checkOutput("start+abort stays idle", nDone, 0);

        // Leave a valid result behind, then reset part-way through an OR sweep.
        applyStimulus(vecs[0], 0, 0, 1'b0);
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("busy before reset", int'(busy), 1);
        checkOutput("a_o before reset", int'(a_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset a_o", int'(a_o), 0);
        checkOutput("async reset busy", int'(busy), 0);
        checkOutput("async reset done", int'(done), 0);
        checkOutput("async reset truth_table", int'(truth_table), 0);
        checkOutput("async reset gate_id", int'(gate_id), 7);
        checkOutput("async reset valid_gate", int'(valid_gate), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vecs[3], 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
